div_issue_ctrl: RTL
===================

// Module: div_issue_ctrl
// PURPOSE
//  Request front-end sitting directly upstream of the 32-bit divider. Buffers divide requests
//  (valid/ready) in a small FIFO, issues them one at a time with a single-cycle start pulse,
//  waits for done or a timeout, and returns quotient/remainder/error with the request tag.
//  Every divider operand and start signal comes from this block; every result goes back through it.
// PARAMETERS
//  DATA_W   32  operand/result width; matches the divider
//  DEPTH    4   request FIFO entries; power of 2, >=2
//  TAG_W    4   opaque request tag, returned unchanged
//  TIMEOUT  64  WAIT cycles without div_done before a timeout error; >=1
// PORTS
//  clk            in   1                   single clock, all logic rising-edge
//  reset          in   1                   asynchronous, active-low
//  req_valid      in   1                   request present
//  req_ready      out  1                   request accepted when valid&&ready
//  req_dividend   in   DATA_W              dividend
//  req_divisor    in   DATA_W              divisor
//  req_sign       in   1                   1 = signed divide
//  req_tag        in   TAG_W               request tag
//  div_dividend   out  DATA_W              to divider dividendIn
//  div_divisor    out  DATA_W              to divider divisorIn
//  div_sign       out  1                   to divider sign
//  div_start      out  1                   to divider start; one-cycle pulse
//  div_quotient   in   DATA_W              from divider quotientOut
//  div_remainder  in   DATA_W              from divider remainderOut
//  div_error      in   1                   from divider error
//  div_done       in   1                   from divider done; results valid this cycle
//  rsp_valid      out  1                   response present
//  rsp_ready      in   1                   response consumed when valid&&ready
//  rsp_quotient   out  DATA_W              result quotient (0 on timeout)
//  rsp_remainder  out  DATA_W              result remainder (0 on timeout)
//  rsp_error      out  1                   divider error or timeout
//  rsp_timeout    out  1                   timeout occurred
//  rsp_tag        out  TAG_W               tag of the completed request
//  busy           out  1                   FSM not IDLE or FIFO not empty
//  fifo_count     out  $clog2(DEPTH)+1     FIFO occupancy
// BEHAVIOUR
//  Reset (reset==0): all state cleared asynchronously. FIFO is emptied and any in-flight op is dropped.
//   All outputs are 0 except req_ready=1. The divider shares this reset.
//  FIFO
//   - req_ready = !full; no write bypass when full.
//   - A push into an empty FIFO is visible to the FSM the next cycle.
//   - Simultaneous push and pop is legal whenever not full; fifo_count is unchanged.
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE
//   IDLE : if !empty, pop the head into operand/tag regs, go to ISSUE.
//   ISSUE: div_start=1 for exactly this cycle; clear the timer; go to WAIT.
//   WAIT : on div_done, capture quotient, remainder and error; set timeout=0; go to RESP.
//          Otherwise increment the timer. On the TIMEOUT-th WAIT cycle without done:
//          error=1, timeout=1, quotient=remainder=0; go to RESP.
//          If done and the timeout limit fall in the same cycle, done wins.
//   RESP : rsp_valid=1 with all rsp_* fields stable; on rsp_ready go to IDLE.
//  - div_dividend, div_divisor and div_sign are registered. They hold from ISSUE until the next pop.
//  - div_done is ignored outside WAIT.
//  - Latency: request accepted in cycle N into an idle empty block -> pop in N+1 -> div_start in N+2.
//    div_done in cycle D -> rsp_valid in D+1. Response handshake in cycle R -> next div_start in R+2.
//  - Exactly one divide is outstanding at a time; responses return in request order.
//  - Operands pass through unmodified; sign and width handling belong to the divider.
//  - Timer width is $clog2(TIMEOUT+1) and it never wraps.
// STRUCTURE
//  div_pkg holds:
//   - DATA_W and TAG_W defaults
//   - typedef div_req_t {dividend, divisor, sign, tag}
//   - typedef div_rsp_t {quotient, remainder, error, timeout, tag}
//   - enum div_issue_state_e {IDLE, ISSUE, WAIT, RESP}
//  Sub-module div_req_fifo: synchronous FIFO of div_req_t, DEPTH entries, with count/full/empty.
//  The FSM, operand regs, timer and response regs stay in this module.
// TESTING
//  1. Request 100/7, sign=0, tag=3; model asserts done 32 cycles after start with q=14, r=2
//     -> one start pulse at N+2 with operands 100/7; rsp q=14 r=2 err=0 tag=3 at D+1.
//  2. Five requests pushed on consecutive cycles with DEPTH=4 and the divider stalled
//     -> all five accepted; req_ready=0 from cycle 5; fifo_count=4; responses return tags in order.
//  3. Request 5/0; model returns error=1 -> rsp_error=1, rsp_timeout=0, tag preserved.
//  4. Model never asserts done, TIMEOUT=64, start in cycle S
//     -> rsp_valid at S+65 with err=1, timeout=1, q=r=0; next queued request then starts normally.
//  5. Hold rsp_ready=0 for 10 cycles with 2 requests queued
//     -> rsp fields stable throughout; no div_start until 2 cycles after the handshake.
//  6. Assert reset during WAIT with 3 queued
//     -> outputs 0 immediately, req_ready=1, fifo_count=0; after release a new -100/7, sign=1
//        request issues fresh with div_sign=1.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and default widths for the divider request front-end.
package div_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_TAG_W  = 4;

  typedef struct packed {
    logic [DIV_DATA_W-1:0] dividend;
    logic [DIV_DATA_W-1:0] divisor;
    logic                  sign;
    logic [DIV_TAG_W-1:0]  tag;
  } div_req_t;

  typedef struct packed {
    logic [DIV_DATA_W-1:0] quotient;
    logic [DIV_DATA_W-1:0] remainder;
    logic                  error;
    logic                  timeout;
    logic [DIV_TAG_W-1:0]  tag;
  } div_rsp_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } div_issue_state_e;

endpackage

// File: rtl/div_req_fifo.sv
// Small first-word-fall-through request FIFO; the head entry is readable while not empty.
module div_req_fifo
  import div_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  div_req_t                 push_data,
  input  logic                     pop,
  output div_req_t                 head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  div_req_t mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;
  assign head    = mem[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Divider front-end: queues requests, issues one divide at a time with a start pulse,
// waits for done or a timeout, and returns the result with the request tag.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int DATA_W  = DIV_DATA_W,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = DIV_TAG_W,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [DATA_W-1:0]       req_dividend,
  input  logic [DATA_W-1:0]       req_divisor,
  input  logic                    req_sign,
  input  logic [TAG_W-1:0]        req_tag,
  output logic [DATA_W-1:0]       div_dividend,
  output logic [DATA_W-1:0]       div_divisor,
  output logic                    div_sign,
  output logic                    div_start,
  input  logic [DATA_W-1:0]       div_quotient,
  input  logic [DATA_W-1:0]       div_remainder,
  input  logic                    div_error,
  input  logic                    div_done,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_W-1:0]       rsp_quotient,
  output logic [DATA_W-1:0]       rsp_remainder,
  output logic                    rsp_error,
  output logic                    rsp_timeout,
  output logic [TAG_W-1:0]        rsp_tag,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  div_req_t         push_req;
  div_req_t         head_req;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;

  div_issue_state_e state_q, state_d;
  div_req_t         op_q, op_d;
  div_rsp_t         rsp_q, rsp_d;
  logic             start_q, start_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [TMR_W-1:0] timer_q, timer_d;

  assign push_req = '{dividend: req_dividend, divisor: req_divisor,
                      sign: req_sign, tag: req_tag};
  assign req_ready = !fifo_full;

  div_req_fifo #(
    .DEPTH(DEPTH)
  ) u_req_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (req_valid && req_ready),
    .push_data(push_req),
    .pop      (fifo_pop),
    .head     (head_req),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rsp_d       = rsp_q;
    start_d     = 1'b0;
    rsp_valid_d = rsp_valid_q;
    timer_d     = timer_q;
    fifo_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          op_d     = head_req;
          start_d  = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A done arriving on the last allowed cycle still beats the timeout.
        if (div_done) begin
          rsp_d = '{quotient: div_quotient, remainder: div_remainder,
                    error: div_error, timeout: 1'b0, tag: op_q.tag};
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (timer_q == TMR_LAST) begin
          rsp_d = '{quotient: '0, remainder: '0,
                    error: 1'b1, timeout: 1'b1, tag: op_q.tag};
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      rsp_q       <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rsp_q       <= rsp_d;
      start_q     <= start_d;
      rsp_valid_q <= rsp_valid_d;
      timer_q     <= timer_d;
    end
  end

  assign div_dividend  = op_q.dividend;
  assign div_divisor   = op_q.divisor;
  assign div_sign      = op_q.sign;
  assign div_start     = start_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_quotient  = rsp_q.quotient;
  assign rsp_remainder = rsp_q.remainder;
  assign rsp_error     = rsp_q.error;
  assign rsp_timeout   = rsp_q.timeout;
  assign rsp_tag       = rsp_q.tag;
  assign busy          = (state_q != IDLE) || !fifo_empty;

endmodule
